// File: rtl/csa_sum_accumulator.sv
// csa_sum_accumulator: sums COUNT adder results {carry_in, sum_in} per block and hands the total downstream
// Ports: clk/rst (async, active-high) clock and reset; clear synchronously aborts the block;
//        in_valid/in_ready/sum_in/carry_in form the input handshake for adder results;
//        out_valid/out_ready/total/overflow form the output handshake for block results;
//        sample_cnt counts the results accepted in the current block.
module csa_sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       sum_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] total,
  output logic             overflow,
  output logic [7:0]       sample_cnt
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, total_q, total_d;
  logic ovf_q, ovf_d, overflow_q, overflow_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ACC_W:0] sum_w;
  logic accept, last;
  assign in_ready   = !rst && state_q == ACCUM;
  assign out_valid  = state_q == DONE;
  assign total      = total_q;
  assign overflow   = overflow_q;
  assign sample_cnt = cnt_q;
  assign accept     = in_valid && in_ready;
  assign last       = cnt_q == 8'(COUNT - 1);
  // bit ACC_W is the carry out of the accumulator's top bit
  assign sum_w      = {1'b0, acc_q} + (ACC_W + 1)'({carry_in, sum_in});
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    if (clear || (out_valid && out_ready)) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      acc_d = sum_w[ACC_W-1:0];
      ovf_d = ovf_q | sum_w[ACC_W];
      cnt_d = cnt_q + 8'd1;
      if (last) begin
        total_d    = sum_w[ACC_W-1:0];
        overflow_d = ovf_q | sum_w[ACC_W];
        state_d    = DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_csa_sum_accumulator.sv
// tb_csa_sum_accumulator: directed checks of the block accumulator at ACC_W=16 and ACC_W=10
module tb_csa_sum_accumulator;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0, carry_in = 1'b0;
  logic [7:0] sum_in = '0;
  logic a_in_ready, a_out_valid, a_overflow, b_in_ready, b_out_valid, b_overflow;
  logic [15:0] a_total;
  logic [9:0] b_total;
  logic [7:0] a_cnt, b_cnt;
  int checks = 0, failures = 0;
  csa_sum_accumulator #(.COUNT(4), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(a_in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .total(a_total), .overflow(a_overflow), .sample_cnt(a_cnt));
  csa_sum_accumulator #(.COUNT(4), .ACC_W(10)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(b_in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .total(b_total), .overflow(b_overflow), .sample_cnt(b_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] s, input logic c);
    in_valid = 1'b1;
    sum_in = s;
    carry_in = c;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("hs_cnt", {24'b0, a_cnt}, 32'd0);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_total", {16'b0, a_total}, 32'd0);
    chk("rst_overflow", {31'b0, a_overflow}, 32'd0);
    chk("rst_cnt", {24'b0, a_cnt}, 32'd0);
    #11 rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'b0, a_in_ready}, 32'd1);
    // four maximal operands 510 each: 2040
    for (int i = 0; i < 3; i++) put(8'hFE, 1'b1);
    chk("t1_cnt3", {24'b0, a_cnt}, 32'd3);
    chk("t1_not_done", {31'b0, a_out_valid}, 32'd0);
    put(8'hFE, 1'b1);
    chk("t1_out_valid", {31'b0, a_out_valid}, 32'd1);
    chk("t1_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("t1_total16", {16'b0, a_total}, 32'h07F8);
    chk("t1_ovf16", {31'b0, a_overflow}, 32'd0);
    chk("t1_cnt4", {24'b0, a_cnt}, 32'd4);
    chk("t1_total10", {22'b0, b_total}, 32'h3F8);
    chk("t1_ovf10", {31'b0, b_overflow}, 32'd1);
    handshake();
    // zeros block clears the sticky overflow
    for (int i = 0; i < 4; i++) put(8'h00, 1'b0);
    chk("t2_out_valid10", {31'b0, b_out_valid}, 32'd1);
    chk("t2_total10", {22'b0, b_total}, 32'd0);
    chk("t2_ovf10", {31'b0, b_overflow}, 32'd0);
    handshake();
    // gapped input: valid pattern 1,0,0,1,0,1,1 with operands 1..4
    put(8'd1, 1'b0);
    tick();
    tick();
    chk("t3_gap_cnt", {24'b0, a_cnt}, 32'd1);
    put(8'd2, 1'b0);
    tick();
    chk("t3_gap_cnt2", {24'b0, a_cnt}, 32'd2);
    put(8'd3, 1'b0);
    chk("t3_not_done", {31'b0, a_out_valid}, 32'd0);
    put(8'd4, 1'b0);
    chk("t3_out_valid", {31'b0, a_out_valid}, 32'd1);
    chk("t3_total", {16'b0, a_total}, 32'd10);
    // back-pressure in DONE with in_valid held high
    in_valid = 1'b1;
    sum_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_in_ready", {31'b0, a_in_ready}, 32'd0);
      chk("t4_stall_total", {16'b0, a_total}, 32'd10);
      chk("t4_stall_cnt", {24'b0, a_cnt}, 32'd4);
    end
    sum_in = 8'd7;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_hs_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("t4_hs_not_accepted", {24'b0, a_cnt}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t4_first_accept", {24'b0, a_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) put(8'd0, 1'b0);
    chk("t4_fresh_total", {16'b0, a_total}, 32'd7);
    handshake();
    // async reset mid-block
    put(8'd5, 1'b0);
    put(8'd6, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_cnt", {24'b0, a_cnt}, 32'd0);
    chk("t5_rst_total", {16'b0, a_total}, 32'd0);
    chk("t5_rst_in_ready", {31'b0, a_in_ready}, 32'd0);
    #2 rst = 1'b0;
    put(8'd10, 1'b0);
    put(8'd20, 1'b0);
    put(8'd30, 1'b0);
    put(8'd40, 1'b0);
    chk("t5_total", {16'b0, a_total}, 32'd100);
    chk("t5_out_valid", {31'b0, a_out_valid}, 32'd1);
    handshake();
    // clear drops a coincident operand
    for (int i = 0; i < 3; i++) put(8'd1, 1'b0);
    clear = 1'b1;
    put(8'd50, 1'b0);
    clear = 1'b0;
    chk("t6_clear_cnt", {24'b0, a_cnt}, 32'd0);
    chk("t6_clear_out_valid", {31'b0, a_out_valid}, 32'd0);
    put(8'd2, 1'b0);
    put(8'd3, 1'b0);
    put(8'd4, 1'b0);
    put(8'd5, 1'b0);
    chk("t6_total", {16'b0, a_total}, 32'd14);
    chk("t6_done", {31'b0, a_out_valid}, 32'd1);
    // clear beats a simultaneous output handshake
    clear = 1'b1;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    chk("t6_clear_done_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("t6_clear_done_cnt", {24'b0, a_cnt}, 32'd0);
    chk("t6_clear_done_total", {16'b0, a_total}, 32'd14);
    for (int i = 0; i < 4; i++) put(8'd1, 1'b0);
    chk("t6_next_total", {16'b0, a_total}, 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/csa_sum_accumulator.md
Name: csa_sum_accumulator

Overview:
Downstream consumer of the 8-bit conditional sum adder. Accepts the adder's {CarryOut, Sum} result as a 9-bit unsigned value over a valid/ready handshake. Accumulates COUNT consecutive results into a wide running total, then presents the total on an output valid/ready handshake. Used to build block checksums and multi-operand sums from the combinational adder without widening it.

Parameters:
COUNT, 4, number of accepted adder results per block (legal range 1..255)
ACC_W, 16, accumulator/total width in bits (legal range 9..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous abort of the current block
in_valid  input  1  sum_in/carry_in hold a valid adder result
in_ready  output  1  block can accept a result this cycle
sum_in  input  8  adder Sum
carry_in  input  1  adder CarryOut
out_valid  output  1  total/overflow hold a completed block result
out_ready  input  1  downstream accepts the result
total  output  ACC_W  block sum, modulo 2^ACC_W
overflow  output  1  block sum exceeded 2^ACC_W-1
sample_cnt  output  8  results accepted in the current block

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=ACCUM, accumulator=0, sample_cnt=0, total=0, overflow=0, out_valid=0. in_ready=0 while rst=1.
- Accepted operand = {carry_in, sum_in}, zero-extended to ACC_W+1 bits (range 0..510).
- Input handshake: accept on a rising edge where in_valid=1 and in_ready=1. Output handshake: complete on a rising edge where out_valid=1 and out_ready=1.
- States:
  - ACCUM: in_ready=1, out_valid=0. On accept: acc <= acc+operand (mod 2^ACC_W); ovf_sticky |= carry out of bit ACC_W-1; sample_cnt increments. If this is the COUNT-th accept: total <= new acc, overflow <= new sticky, state -> DONE.
  - DONE: in_ready=0, out_valid=1. total/overflow stay stable until handshake. On handshake: acc, sticky, and sample_cnt clear; state -> ACCUM. total/overflow keep their last values; they are ignored while out_valid=0.
- Latency: out_valid rises in the cycle after the edge that accepted the COUNT-th result. No combinational path from input data to outputs.
- in_valid gaps are allowed in ACCUM; the state holds with no change.
- out_ready held low in DONE: stays in DONE indefinitely and ignores in_valid. Upstream data must be held by its producer.
- Output handshake and a new in_valid on the same edge: the input is not accepted, because in_ready=0 in DONE. The first accept is possible on the following cycle.
- clear=1 (synchronous, highest priority after rst): acc, sticky, and sample_cnt go to 0, state -> ACCUM, out_valid -> 0. Any simultaneous input or output handshake is discarded.
- rst mid-block or in DONE: immediate return to reset values; the partial or pending result is lost.
- COUNT=1: every accept goes straight to DONE.
- sample_cnt: 0..COUNT-1 in ACCUM; reads COUNT in DONE.

Test Plan:
- Reset, then 4 accepts of sum_in=8'hFE, carry_in=1 (255+255) -> out_valid=1 on the cycle after the 4th accept; total=16'h07F8; overflow=0; sample_cnt=4.
- ACC_W=10 override, same 4 operands -> total=10'h3F8 (2040 mod 1024); overflow=1. Next block of 4 zeros -> total=0, overflow=0 (sticky cleared).
- in_valid toggled 1,0,0,1,0,1,1 with operands 1,2,3,4 -> total=10 only after the 4th accepted operand; idle cycles leave sample_cnt unchanged.
- out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0 and total is stable throughout. out_ready=1 -> returns to ACCUM; the next accepted operand starts a fresh sum.
- Assert rst after 2 accepts (asynchronously, mid-cycle) -> outputs go to reset values immediately. A new 4-operand block of 10,20,30,40 -> total=100.
- clear after 3 accepts, coincident with in_valid=1 -> the operand is dropped and sample_cnt=0. clear asserted in DONE while out_ready=1 -> no output handshake occurs and out_valid=0 on the next cycle.
